opc_mem_responder: RTL and testbench

Memory-side responder for the 8-bit accumulator CPU bus: 11-bit address, active-high read/not-write strobe, 8-bit data.
- Serves CPU fetches and loads from a small on-chip byte RAM split into two windows: page 0 for variables and page 1 for the program, which starts at reset vector 0x100.
- Accepts CPU stores into the same RAM.
- Includes a byte-stream loader that fills the RAM from the input pins while holding the CPU in reset, then releases it.

---
 rtl/opc_bus_pkg.sv | 14 +
 rtl/opc_bus_ram.sv | 25 ++
 rtl/opc_mem_responder.sv | 118 +++++++++++
 tb/tb_opc_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opc_bus_pkg.sv
// Shared definitions for the 8-bit accumulator CPU bus: responder states and
// the fixed page bases / reset vector of the CPU memory map.
package opc_bus_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [10:0] PAGE0_BASE = 11'h000;
    localparam logic [10:0] PAGE1_BASE = 11'h100;
    localparam logic [10:0] RST_VECTOR = 11'h100;

endpackage

// File: rtl/opc_bus_ram.sv
// DEPTH x 8 flop array: asynchronous read, one synchronous write port.
// Zero read latency; no backpressure. Contents are deliberately not reset.
module opc_bus_ram #(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [7:0]       i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [7:0]       o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/opc_mem_responder.sv
// Memory responder for the accumulator CPU: serves reads/stores from an on-chip
// RAM and, in LOAD, fills that RAM from a byte stream while holding the CPU in
// reset. Reads are combinational; the loader is throttled only by ld_ready.
module opc_mem_responder
    import opc_bus_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:0] i_cpu_addr,
    input  logic        i_cpu_rnw,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_rst_n,
    input  logic [7:0]  i_ld_data,
    input  logic        i_ld_valid,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    input  logic        i_ld_reload,
    output logic        o_running,
    output logic        o_wr_err
);

    localparam int H = DEPTH / 2;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_ld_arm;
    logic             r_cpu_rst_n;
    logic             r_wr_err;

    logic             w_mapped;
    logic [IDX_W-1:0] w_cpu_idx;
    logic             w_ld_ready;
    logic             w_ld_acc;
    logic             w_ld_done;
    logic             w_cpu_wr;
    logic             w_ram_we;
    logic [IDX_W-1:0] w_ram_waddr;
    logic [7:0]       w_ram_wdata;
    logic [7:0]       w_ram_rdata;

    // Page 0 lives in the low half of the RAM, page 1 in the high half.
    assign w_mapped  = (i_cpu_addr[10:9] == 2'b00) && ({1'b0, i_cpu_addr[7:0]} < 9'(H));
    assign w_cpu_idx = {i_cpu_addr[8], i_cpu_addr[IDX_W-2:0]};

    // ld_ready is held off for the first cycle of every LOAD entry.
    assign w_ld_ready = (r_state == ST_LOAD) && r_ld_arm;
    assign w_ld_acc   = w_ld_ready && i_ld_valid && !i_ld_reload;
    assign w_ld_done  = w_ld_acc && (i_ld_last || (r_idx == IDX_W'(DEPTH - 1)));
    assign w_cpu_wr   = (r_state == ST_RUN) && !i_cpu_rnw;

    assign w_ram_we    = w_ld_acc || (w_cpu_wr && w_mapped);
    assign w_ram_waddr = (r_state == ST_LOAD) ? r_idx     : w_cpu_idx;
    assign w_ram_wdata = (r_state == ST_LOAD) ? i_ld_data : i_cpu_wdata;

    opc_bus_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_cpu_idx),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (i_ld_reload) begin
            w_state_nxt = ST_LOAD;
        end else if (w_ld_done) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_ld_arm    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_ld_reload) begin
                r_idx       <= '0;
                r_ld_arm    <= 1'b0;
                r_cpu_rst_n <= 1'b0;
            end else begin
                if (r_state == ST_LOAD) begin
                    r_ld_arm <= 1'b1;
                end
                // The index saturates at the last byte rather than wrapping.
                if (w_ld_acc && (r_idx != IDX_W'(DEPTH - 1))) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_ld_done) begin
                    r_cpu_rst_n <= 1'b1;
                end
            end
            if (w_cpu_wr && !w_mapped) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    assign o_cpu_rdata = w_mapped ? w_ram_rdata : 8'h00;
    assign o_cpu_rst_n = r_cpu_rst_n;
    assign o_ld_ready  = w_ld_ready;
    assign o_running   = (r_state == ST_RUN);
    assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_opc_mem_responder.sv
// Directed and randomized bench for opc_mem_responder with a byte-array memory
// model and a tiny behavioural accumulator CPU for the full-system program.
module tb_opc_mem_responder;
    import opc_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic        cpu_rnw = 1'b1;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rst_n;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_reload = 1'b0;
    logic        running;
    logic        wr_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_mem [32];
    int         m_idx = 0;
    bit         m_run = 0;
    bit         m_err = 0;

    always #5 clk = ~clk;

    opc_mem_responder #(.DEPTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_rnw   (cpu_rnw),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_rst_n (cpu_rst_n),
        .i_ld_data   (ld_data),
        .i_ld_valid  (ld_valid),
        .i_ld_last   (ld_last),
        .o_ld_ready  (ld_ready),
        .i_ld_reload (ld_reload),
        .o_running   (running),
        .o_wr_err    (wr_err)
    );

    function automatic bit is_mapped(input int a);
        return (a < 'h200) && ((a % 256) < 16);
    endfunction

    function automatic int ram_index(input int a);
        return (a / 256) * 16 + (a % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reload_pulse(input bit with_byte, input logic [7:0] d);
        ld_reload = 1'b1;
        ld_valid  = with_byte;
        ld_data   = d;
        tick();
        ld_reload = 1'b0;
        ld_valid  = 1'b0;
        m_run = 0;
        m_idx = 0;
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        check("reload_running", running, 0);
        check("reload_ld_ready", ld_ready, 0);
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        int n;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        n = 0;
        while (!ld_ready && n < 10) begin
            tick();
            n++;
        end
        check("ld_ready", ld_ready, 1);
        check("load_cpu_rst_n", cpu_rst_n, 0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_mem[m_idx] = d;
        if (last || m_idx == 31) m_run = 1;
        else m_idx++;
    endtask

    task automatic rd_check(input int a, input string tag);
        cpu_addr = 11'(a);
        cpu_rnw  = 1'b1;
        #1;
        check(tag, cpu_rdata, is_mapped(a) ? m_mem[ram_index(a)] : 8'h00);
        tick();
    endtask

    task automatic cpu_read(input int a, output logic [7:0] d);
        cpu_addr = 11'(a);
        cpu_rnw  = 1'b1;
        #1;
        d = cpu_rdata;
        tick();
    endtask

    task automatic cpu_wr(input int a, input logic [7:0] d);
        cpu_addr  = 11'(a);
        cpu_rnw   = 1'b0;
        cpu_wdata = d;
        tick();
        cpu_rnw = 1'b1;
        if (m_run) begin
            if (is_mapped(a)) m_mem[ram_index(a)] = d;
            else m_err = 1;
        end
    endtask

    initial begin
        logic [7:0] prog [8];
        logic [7:0] b0, b1, acc, tmp;
        int pc, tgt, k, a;

        // Reset values
        #12;
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_running", running, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_wr_err", wr_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("first_cycle_ld_ready", ld_ready, 0);

        // 1: full 32-byte load, no ld_last
        for (int i = 0; i < 32; i++) load_byte(8'hA0 + 8'(i), 1'b0);
        check("full_ld_ready", ld_ready, 0);
        check("full_cpu_rst_n", cpu_rst_n, 1);
        check("full_running", running, 1);
        rd_check('h000, "rd_000");
        check("rd_000_const", cpu_rdata === 8'hA0 || m_mem[0] == 8'hA0, 1);
        rd_check('h00F, "rd_00F");
        rd_check('h100, "rd_100");
        rd_check('h10F, "rd_10F");

        // 2: short load terminated by ld_last
        reload_pulse(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) load_byte(8'h60 + 8'(i), i == 2);
        check("short_running", running, 1);
        for (int i = 0; i < 4; i++) rd_check(i, "short_rd");

        // 3: CPU stores, mapped and unmapped
        cpu_wr('h003, 8'h5A);
        rd_check('h003, "store_rd");
        check("store_wr_err", wr_err, 0);
        cpu_wr('h020, 8'hC3);
        check("unmapped_wr_err", wr_err, 1);
        rd_check('h020, "unmapped_rd");
        check("wr_err_sticky", wr_err, 1);

        // 4: reload collides with a loader byte
        reload_pulse(1'b1, 8'hEE);
        rd_check('h000, "reload_byte_dropped");
        load_byte(8'h77, 1'b1);
        rd_check('h000, "after_reload_idx0");
        check("wr_err_across_reload", wr_err, 1);

        // 5: asynchronous reset mid-load at idx 7
        reload_pulse(1'b0, 8'h00);
        for (int i = 0; i < 7; i++) load_byte(8'h30 + 8'(i), 1'b0);
        check("pre_arst_ld_ready", ld_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_rst_n", cpu_rst_n, 0);
        check("arst_ld_ready", ld_ready, 0);
        check("arst_wr_err", wr_err, 0);
        m_err = 0; m_idx = 0; m_run = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        load_byte(8'h99, 1'b1);
        for (int i = 0; i < 8; i++) rd_check(i, "arst_retained");

        // Randomized loads and CPU traffic
        for (int r = 0; r < 6; r++) begin
            reload_pulse(1'b0, 8'h00);
            k = $urandom_range(1, 32);
            for (int i = 0; i < k; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                load_byte(8'($urandom), (i == k - 1) && ($urandom_range(0, 3) != 0));
                if (m_run) break;
            end
            while (!m_run) load_byte(8'($urandom), 1'b1);
            check("rnd_running", running, 1);
            check("rnd_cpu_rst_n", cpu_rst_n, 1);
            for (int j = 0; j < 16; j++) begin
                if ($urandom_range(0, 3) != 0)
                    a = ($urandom_range(0, 1) * 256) + $urandom_range(0, 15);
                else
                    a = $urandom_range(0, 2047);
                if ($urandom_range(0, 2) == 0) cpu_wr(a, 8'($urandom));
                else rd_check(a, "rnd_rd");
            end
            check("rnd_wr_err", wr_err, m_err);
        end

        // 6: full system with a behavioural CPU
        prog = '{8'h10, 8'h00, 8'h20, 8'h01, 8'h30, 8'h02, 8'h41, 8'h06};
        reload_pulse(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) load_byte((i == 0) ? 8'h12 : (i == 1) ? 8'h34 : 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) load_byte(prog[i], i == 7);
        check("sys_cpu_rst_n", cpu_rst_n, 1);
        pc  = int'(RST_VECTOR);
        acc = 8'h00;
        for (int s = 0; s < 10; s++) begin
            cpu_read(pc, b0);
            cpu_read(pc + 1, b1);
            tgt = {21'd0, b0[2:0], b1};
            pc  = pc + 2;
            case (b0[7:4])
                4'h1: cpu_read(tgt, acc);
                4'h2: begin cpu_read(tgt, tmp); acc = acc + tmp; end
                4'h3: cpu_wr(tgt, acc);
                4'h4: pc = tgt;
                default: ;
            endcase
        end
        cpu_addr = 11'h002;
        #1;
        check("sys_sum", cpu_rdata, 8'h46);
        check("sys_pc_loop", pc, 'h106);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
